cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the two writeback producers: ALU results and LSB load results.
- The reservation station, LSB and ROB all snoop the CDB, so one result per cycle is broadcast.
- Each source gets a small FIFO so that a losing result waits instead of being lost.
- Stall outputs throttle RS issue and LSB completion before either FIFO overflows; a ROB misbranch flushes all pending results.

---
 rtl/cdb_arbiter_pkg.sv | 19 +
 rtl/cdb_src_fifo.sv | 75 +++++++
 rtl/cdb_arbiter.sv | 147 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared widths, ROB position type and CDB source encodings
package cdb_arbiter_pkg;

  localparam int CDB_DATA_W = 32;
  localparam int CDB_ROB_W  = 4;
  localparam int CDB_DEPTH  = 4;

  typedef logic [CDB_ROB_W-1:0]  rob_pos_t;
  typedef logic [CDB_DATA_W-1:0] cdb_data_t;

  // ROB position 0 never names a real entry, so it doubles as "no result"
  localparam rob_pos_t ZERO_ROB = '0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source result FIFO holding {pos, value, io}
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W = CDB_DATA_W,
  parameter int ROB_W  = CDB_ROB_W,
  parameter int DEPTH  = CDB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [ROB_W-1:0]         push_pos_i,
  input  logic [DATA_W-1:0]        push_value_i,
  input  logic                     push_io_i,
  input  logic                     pop_i,
  output logic [ROB_W-1:0]         head_pos_o,
  output logic [DATA_W-1:0]        head_value_o,
  output logic                     head_io_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ROB_W + DATA_W + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign {head_pos_o, head_value_o, head_io_o} = mem_q[rd_ptr_q];
  // count_o is the post-update occupancy so the owner can register stalls from it
  assign count_o = count_d;

  // Accept a push when there is room or the head leaves in the same cycle
  always_comb begin
    wr_en   = push_i && (!full_o || pop_i) && !flush_i;
    rd_en   = pop_i && !empty_o && !flush_i;
    count_d = count_q;
    if (flush_i)
      count_d = '0;
    else
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
  end

  // Pointer and occupancy state; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (en_i) begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (en_i && wr_en) mem_q[wr_ptr_q] <= {push_pos_i, push_value_i, push_io_i};
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB arbiter between ALU and LSB results; CDB_ARB_LSB_PRIO_EN selects fixed LSB priority
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W = CDB_DATA_W,
  parameter int ROB_W  = CDB_ROB_W,
  parameter int DEPTH  = CDB_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic [ROB_W-1:0]  in_alu_pos,
  input  logic [DATA_W-1:0] in_alu_value,
  input  logic [ROB_W-1:0]  in_lsb_pos,
  input  logic [DATA_W-1:0] in_lsb_value,
  input  logic              in_lsb_io_in,
  input  logic              in_rob_xbp,
  output logic [ROB_W-1:0]  out_cdb_pos,
  output logic [DATA_W-1:0] out_cdb_value,
  output logic              out_cdb_io,
  output logic              out_cdb_src,
  output logic              out_alu_stall,
  output logic              out_lsb_stall,
  output logic              out_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ROB_W-1:0] NO_POS = ROB_W'(ZERO_ROB);

  logic [ROB_W-1:0]  alu_head_pos, lsb_head_pos, sel_pos, cdb_pos_q;
  logic [DATA_W-1:0] alu_head_value, lsb_head_value, sel_value, cdb_value_q;
  logic              alu_head_io, lsb_head_io, sel_io, cdb_io_q;
  cdb_src_e          sel_src, cdb_src_q;
  logic [CW-1:0]     alu_count_d, lsb_count_d;
  logic              alu_full, alu_empty, lsb_full, lsb_empty;
  logic              act, flush, win_lsb;
  logic              alu_live, lsb_live, alu_cand, lsb_cand, alu_gnt, lsb_gnt;
  logic              alu_pop, lsb_pop, alu_push, lsb_push, alu_drop, lsb_drop;
  logic              alu_stall_q, lsb_stall_q, overflow_q;
`ifndef CDB_ARB_LSB_PRIO_EN
  cdb_src_e          rr_last_q;
`endif

  assign act   = rdy && !in_rob_xbp;
  assign flush = rdy && in_rob_xbp;

  // Candidate selection, grant, and the FIFO push/pop/drop decisions
  always_comb begin
    alu_live = (in_alu_pos != NO_POS);
    lsb_live = (in_lsb_pos != NO_POS);
    alu_cand = !alu_empty || alu_live;
    lsb_cand = !lsb_empty || lsb_live;
`ifdef CDB_ARB_LSB_PRIO_EN
    win_lsb  = 1'b1;
`else
    win_lsb  = (rr_last_q == SRC_ALU);
`endif
    lsb_gnt  = lsb_cand && (!alu_cand || win_lsb);
    alu_gnt  = alu_cand && !lsb_gnt;
    alu_pop  = act && alu_gnt && !alu_empty;
    lsb_pop  = act && lsb_gnt && !lsb_empty;
    // a live input goes to its FIFO unless it was broadcast straight through
    alu_push = act && alu_live && !(alu_gnt && alu_empty);
    lsb_push = act && lsb_live && !(lsb_gnt && lsb_empty);
    alu_drop = alu_push && alu_full && !alu_pop;
    lsb_drop = lsb_push && lsb_full && !lsb_pop;
  end

  // Granted entry: FIFO head when one is waiting, otherwise the live input
  always_comb begin
    sel_pos   = alu_empty ? in_alu_pos   : alu_head_pos;
    sel_value = alu_empty ? in_alu_value : alu_head_value;
    sel_io    = alu_empty ? 1'b0         : alu_head_io;
    sel_src   = SRC_ALU;
    if (lsb_gnt) begin
      sel_pos   = lsb_empty ? in_lsb_pos   : lsb_head_pos;
      sel_value = lsb_empty ? in_lsb_value : lsb_head_value;
      sel_io    = lsb_empty ? in_lsb_io_in : lsb_head_io;
      sel_src   = SRC_LSB;
    end
  end

  cdb_src_fifo #(.DATA_W(DATA_W), .ROB_W(ROB_W), .DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .rst_n(rst_n), .en_i(rdy), .flush_i(flush),
    .push_i(alu_push), .push_pos_i(in_alu_pos), .push_value_i(in_alu_value), .push_io_i(1'b0),
    .pop_i(alu_pop), .head_pos_o(alu_head_pos), .head_value_o(alu_head_value), .head_io_o(alu_head_io),
    .count_o(alu_count_d), .full_o(alu_full), .empty_o(alu_empty)
  );

  cdb_src_fifo #(.DATA_W(DATA_W), .ROB_W(ROB_W), .DEPTH(DEPTH)) u_lsb_fifo (
    .clk(clk), .rst_n(rst_n), .en_i(rdy), .flush_i(flush),
    .push_i(lsb_push), .push_pos_i(in_lsb_pos), .push_value_i(in_lsb_value), .push_io_i(in_lsb_io_in),
    .pop_i(lsb_pop), .head_pos_o(lsb_head_pos), .head_value_o(lsb_head_value), .head_io_o(lsb_head_io),
    .count_o(lsb_count_d), .full_o(lsb_full), .empty_o(lsb_empty)
  );

  // CDB output register; value/io/src hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_pos_q   <= NO_POS;
      cdb_value_q <= '0;
      cdb_io_q    <= 1'b0;
      cdb_src_q   <= SRC_ALU;
    end else if (rdy) begin
      if (in_rob_xbp || !(alu_gnt || lsb_gnt)) begin
        cdb_pos_q <= NO_POS;
      end else begin
        cdb_pos_q   <= sel_pos;
        cdb_value_q <= sel_value;
        cdb_io_q    <= sel_io;
        cdb_src_q   <= sel_src;
      end
    end
  end

  // Stalls keep one slot free for a result already in flight; overflow is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_stall_q <= 1'b0;
      lsb_stall_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (rdy) begin
      alu_stall_q <= (alu_count_d >= CW'(DEPTH - 1));
      lsb_stall_q <= (lsb_count_d >= CW'(DEPTH - 1));
      if (alu_drop || lsb_drop) overflow_q <= 1'b1;
    end
  end

`ifndef CDB_ARB_LSB_PRIO_EN
  // Round-robin memory: only a real conflict moves it, so ALU wins the first one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_last_q <= SRC_LSB;
    else if (act && alu_cand && lsb_cand)
      rr_last_q <= lsb_gnt ? SRC_LSB : SRC_ALU;
  end
`endif

  assign out_cdb_pos   = cdb_pos_q;
  assign out_cdb_value = cdb_value_q;
  assign out_cdb_io    = cdb_io_q;
  assign out_cdb_src   = cdb_src_q;
  assign out_alu_stall = alu_stall_q;
  assign out_lsb_stall = lsb_stall_q;
  assign out_overflow  = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;

  localparam int DATA_W = 32;
  localparam int ROB_W  = 4;
  localparam int DEPTH  = 4;
`ifdef CDB_ARB_LSB_PRIO_EN
  localparam bit LSB_PRIO = 1'b1;
`else
  localparam bit LSB_PRIO = 1'b0;
`endif

  logic              clk, rst_n, rdy;
  logic [ROB_W-1:0]  in_alu_pos, in_lsb_pos, out_cdb_pos;
  logic [DATA_W-1:0] in_alu_value, in_lsb_value, out_cdb_value;
  logic              in_lsb_io_in, in_rob_xbp;
  logic              out_cdb_io, out_cdb_src, out_alu_stall, out_lsb_stall, out_overflow;

  typedef struct packed {
    logic [ROB_W-1:0]  pos;
    logic [DATA_W-1:0] value;
    logic              io;
  } exp_t;

  exp_t alu_q[$];
  exp_t lsb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   sb_en    = 1'b1;
  bit   stall_seen;
  int   alu_n;

  cdb_arbiter #(.DATA_W(DATA_W), .ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .in_alu_pos(in_alu_pos), .in_alu_value(in_alu_value),
    .in_lsb_pos(in_lsb_pos), .in_lsb_value(in_lsb_value), .in_lsb_io_in(in_lsb_io_in),
    .in_rob_xbp(in_rob_xbp),
    .out_cdb_pos(out_cdb_pos), .out_cdb_value(out_cdb_value), .out_cdb_io(out_cdb_io),
    .out_cdb_src(out_cdb_src), .out_alu_stall(out_alu_stall), .out_lsb_stall(out_lsb_stall),
    .out_overflow(out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    in_alu_pos   = '0;
    in_alu_value = '0;
    in_lsb_pos   = '0;
    in_lsb_value = '0;
    in_lsb_io_in = 1'b0;
    in_rob_xbp   = 1'b0;
  endtask

  task automatic drive_alu(input int pos, input int value);
    in_alu_pos   = ROB_W'(pos);
    in_alu_value = DATA_W'(value);
  endtask

  task automatic drive_lsb(input int pos, input int value, input bit io);
    in_lsb_pos   = ROB_W'(pos);
    in_lsb_value = DATA_W'(value);
    in_lsb_io_in = io;
  endtask

  // one clock: record expectations, step past the edge, drop inputs, score the CDB
  task automatic cycle();
    bit   rdy_at_edge;
    exp_t e;
    rdy_at_edge = rdy;
    if (sb_en && rdy && !in_rob_xbp) begin
      if (in_alu_pos != '0) alu_q.push_back('{pos: in_alu_pos, value: in_alu_value, io: 1'b0});
      if (in_lsb_pos != '0) lsb_q.push_back('{pos: in_lsb_pos, value: in_lsb_value, io: in_lsb_io_in});
    end
    if (rdy && in_rob_xbp) begin
      alu_q.delete();
      lsb_q.delete();
    end
    @(posedge clk);
    #1;
    clear_inputs();
    if (sb_en && rdy_at_edge && out_cdb_pos != '0) begin
      if (out_cdb_src == 1'b0) begin
        if (alu_q.size() == 0) check_eq("sb_alu_extra", 64'(out_cdb_pos), 64'd0);
        else begin
          e = alu_q.pop_front();
          check_eq("sb_alu_pos", 64'(out_cdb_pos), 64'(e.pos));
          check_eq("sb_alu_value", 64'(out_cdb_value), 64'(e.value));
          check_eq("sb_alu_io", 64'(out_cdb_io), 64'(e.io));
        end
      end else begin
        if (lsb_q.size() == 0) check_eq("sb_lsb_extra", 64'(out_cdb_pos), 64'd0);
        else begin
          e = lsb_q.pop_front();
          check_eq("sb_lsb_pos", 64'(out_cdb_pos), 64'(e.pos));
          check_eq("sb_lsb_value", 64'(out_cdb_value), 64'(e.value));
          check_eq("sb_lsb_io", 64'(out_cdb_io), 64'(e.io));
        end
      end
    end
  endtask

  initial begin
    clear_inputs();
    rdy   = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pos", 64'(out_cdb_pos), 64'd0);
    check_eq("rst_value", 64'(out_cdb_value), 64'd0);
    check_eq("rst_io", 64'(out_cdb_io), 64'd0);
    check_eq("rst_src", 64'(out_cdb_src), 64'd0);
    check_eq("rst_alu_stall", 64'(out_alu_stall), 64'd0);
    check_eq("rst_lsb_stall", 64'(out_lsb_stall), 64'd0);
    check_eq("rst_overflow", 64'(out_overflow), 64'd0);
    rst_n = 1'b1;

    // ALU only, one-cycle latency
    drive_alu(3, 'h11);
    cycle();
    check_eq("alu_only_pos", 64'(out_cdb_pos), 64'd3);
    check_eq("alu_only_value", 64'(out_cdb_value), 64'h11);
    check_eq("alu_only_src", 64'(out_cdb_src), 64'd0);
    cycle();
    check_eq("alu_only_idle", 64'(out_cdb_pos), 64'd0);

    // conflicts: first goes to ALU (round-robin), second to LSB
    drive_alu(2, 'h22);
    drive_lsb(5, 'h55, 1'b0);
    cycle();
    check_eq("conf1_first_src", 64'(out_cdb_src), LSB_PRIO ? 64'd1 : 64'd0);
    check_eq("conf1_first_pos", 64'(out_cdb_pos), LSB_PRIO ? 64'd5 : 64'd2);
    cycle();
    check_eq("conf1_second_src", 64'(out_cdb_src), LSB_PRIO ? 64'd0 : 64'd1);
    check_eq("conf1_second_pos", 64'(out_cdb_pos), LSB_PRIO ? 64'd2 : 64'd5);
    drive_alu(4, 'h44);
    drive_lsb(6, 'h66, 1'b0);
    cycle();
    check_eq("conf2_first_pos", 64'(out_cdb_pos), 64'd6);
    cycle();
    check_eq("conf2_second_pos", 64'(out_cdb_pos), 64'd4);
    cycle();
    check_eq("conf2_idle", 64'(out_cdb_pos), 64'd0);

    // IO flag travels with the LSB entry
    drive_lsb(7, 'h77, 1'b1);
    cycle();
    check_eq("io_pos", 64'(out_cdb_pos), 64'd7);
    check_eq("io_flag", 64'(out_cdb_io), 64'd1);
    cycle();

    // rdy low freezes the outputs and ignores inputs
    drive_alu(3, 'h33);
    cycle();
    rdy = 1'b0;
    drive_alu(9, 'h99);
    cycle();
    check_eq("rdy_hold_pos", 64'(out_cdb_pos), 64'd3);
    check_eq("rdy_hold_value", 64'(out_cdb_value), 64'h33);
    rdy = 1'b1;
    cycle();
    check_eq("rdy_ignored_input", 64'(out_cdb_pos), 64'd0);

    // backlog: ALU burst against an LSB stream that honours its stall
    alu_n      = LSB_PRIO ? 4 : 6;
    stall_seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i < alu_n) drive_alu((i % 15) + 1, 'hA00 + i);
      if (i < 10 && !out_lsb_stall) drive_lsb(((i + 3) % 15) + 1, 'hB00 + i, 1'b0);
      cycle();
      if (out_alu_stall) stall_seen = 1'b1;
    end
    repeat (12) cycle();
    check_eq("backlog_stall_seen", 64'(stall_seen), 64'd1);
    check_eq("backlog_alu_stall_clear", 64'(out_alu_stall), 64'd0);
    check_eq("backlog_lsb_stall_clear", 64'(out_lsb_stall), 64'd0);
    check_eq("backlog_no_overflow", 64'(out_overflow), 64'd0);
    check_eq("backlog_alu_drained", 64'(alu_q.size()), 64'd0);
    check_eq("backlog_lsb_drained", 64'(lsb_q.size()), 64'd0);

    // flush with three entries queued and a live ALU input
    for (int i = 0; i < 3; i++) begin
      drive_alu(1 + i, 'hC00 + i);
      drive_lsb(8 + i, 'hD00 + i, 1'b0);
      cycle();
    end
    in_rob_xbp = 1'b1;
    drive_alu(5, 'h55);
    cycle();
    check_eq("flush_pos", 64'(out_cdb_pos), 64'd0);
    check_eq("flush_alu_stall", 64'(out_alu_stall), 64'd0);
    check_eq("flush_lsb_stall", 64'(out_lsb_stall), 64'd0);
    check_eq("flush_overflow", 64'(out_overflow), 64'd0);
    cycle();
    check_eq("flush_empty1", 64'(out_cdb_pos), 64'd0);
    cycle();
    check_eq("flush_empty2", 64'(out_cdb_pos), 64'd0);

    // overflow by ignoring stalls, then an asynchronous reset mid-cycle
    sb_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_alu((i % 15) + 1, 'hE00 + i);
      drive_lsb(((i + 5) % 15) + 1, 'hF00 + i, 1'b0);
      cycle();
    end
    check_eq("overflow_set", 64'(out_overflow), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_pos", 64'(out_cdb_pos), 64'd0);
    check_eq("arst_value", 64'(out_cdb_value), 64'd0);
    check_eq("arst_overflow", 64'(out_overflow), 64'd0);
    check_eq("arst_alu_stall", 64'(out_alu_stall), 64'd0);
    check_eq("arst_lsb_stall", 64'(out_lsb_stall), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    alu_q.delete();
    lsb_q.delete();
    sb_en = 1'b1;

    // after reset: FIFOs empty and ALU wins the first conflict again
    cycle();
    check_eq("post_rst_idle", 64'(out_cdb_pos), 64'd0);
    drive_alu(2, 'h123);
    drive_lsb(5, 'h456, 1'b0);
    cycle();
    check_eq("post_rst_conf_src", 64'(out_cdb_src), LSB_PRIO ? 64'd1 : 64'd0);
    cycle();
    cycle();
    check_eq("post_rst_idle2", 64'(out_cdb_pos), 64'd0);
    check_eq("final_alu_q_empty", 64'(alu_q.size()), 64'd0);
    check_eq("final_lsb_q_empty", 64'(lsb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
